// File: rtl/lpf_interp_if.sv
// Handshake bundle for the linear-interpolating upsampler: low-rate sample input
// and high-rate interpolated output, each with valid/ready.
interface lpf_interp_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_dat;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_dat;
  logic       out_last;

  modport master (
    output in_valid, in_dat, out_ready,
    input  in_ready, out_valid, out_dat, out_last
  );

  modport slave (
    input  in_valid, in_dat, out_ready,
    output in_ready, out_valid, out_dat, out_last
  );
endinterface

// File: rtl/lpf_interp.sv
// Linear-interpolating upsampler: each accepted 8-bit sample produces 2^UP_LOG2
// outputs ramping from the previous sample toward the new one.
//
// state | meaning
// EMPTY | no segment in progress; waiting for an input sample
// RUN   | emitting segment outputs k = 0 .. N-1
module lpf_interp #(
  parameter int UP_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  lpf_interp_if.slave  bus
);

  localparam int PW = 10 + UP_LOG2;

  typedef enum logic {EMPTY, RUN} state_t;

  state_t               state, state_nxt;
  logic [7:0]           prev, prev_nxt;
  logic [7:0]           cur, cur_nxt;
  logic [UP_LOG2-1:0]   k, k_nxt;
  logic                 primed, primed_nxt;

  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 k_last;

  logic signed [8:0]    diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod;

  assign k_last = &k;

  // Output depends only on registered state; no in_* -> out_* path.
  assign diff   = $signed({1'b0, cur}) - $signed({1'b0, prev});
  assign diff_x = {{(PW-9){diff[8]}}, diff};
  assign k_x    = {{(PW-UP_LOG2){1'b0}}, k};
  assign prod   = diff_x * k_x;

  assign bus.out_dat   = prev + 8'(prod >>> UP_LOG2);
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_valid_c & k_last;
  assign bus.in_ready  = in_ready_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      prev   <= '0;
      cur    <= '0;
      k      <= '0;
      primed <= 1'b0;
    end else begin
      state  <= state_nxt;
      prev   <= prev_nxt;
      cur    <= cur_nxt;
      k      <= k_nxt;
      primed <= primed_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    cur_nxt     = cur;
    k_nxt       = k;
    primed_nxt  = primed;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      EMPTY: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          cur_nxt   = bus.in_dat;
          k_nxt     = '0;
          state_nxt = RUN;
          // First sample after reset ramps from itself, giving N flat copies.
          if (!primed) begin
            prev_nxt   = bus.in_dat;
            primed_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        out_valid_c = 1'b1;
        in_ready_c  = k_last & bus.out_ready;
        if (bus.out_ready) begin
          if (!k_last) begin
            k_nxt = k + 1'b1;
          end else begin
            prev_nxt = cur;
            k_nxt    = '0;
            // Chaining the next sample here keeps out_valid gap-free.
            if (bus.in_valid) begin
              cur_nxt = bus.in_dat;
            end else begin
              state_nxt = EMPTY;
            end
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_lpf_interp.sv
// Directed bench for lpf_interp (N = 8): hand-computed ramps, floor rounding,
// backpressure stability, zero-bubble chaining and mid-segment reset.
module tb_lpf_interp;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  lpf_interp_if bus ();

  lpf_interp #(.UP_LOG2(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample while the block is idle; returns after the transfer edge.
  task automatic send(input logic [7:0] v);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_out_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_dat   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Drain one segment; e holds the 8 expected outputs, first in the top byte.
  task automatic collect(input logic [63:0] e, input bit stall);
    int         i = 0;
    int         guard = 0;
    logic       held = 1'b0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    while (i < 8 && guard < 200) begin
      if (held) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_dat", 32'(bus.out_dat), 32'(hd));
        chk("stall_last", 32'(bus.out_last), 32'(hl));
      end
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.out_valid) begin
        chk("run_in_ready", 32'(bus.in_ready), 32'(bus.out_ready & bus.out_last));
        if (bus.out_ready) begin
          chk("seg_dat", 32'(bus.out_dat), 32'(e[63-8*i -: 8]));
          chk("seg_last", 32'(bus.out_last), (i == 7) ? 1 : 0);
          i++;
          held = 1'b0;
        end else begin
          hd   = bus.out_dat;
          hl   = bus.out_last;
          held = 1'b1;
        end
      end
      @(negedge clk);
      guard++;
    end
    if (i < 8) chk("seg_timeout", 32'(i), 8);
    bus.out_ready = 1'b1;
  endtask

  function automatic logic [7:0] chain_samp(input int j);
    case (j)
      0:       return 8'd0;
      1:       return 8'd64;
      default: return 8'd128;
    endcase
  endfunction

  initial begin
    logic [191:0] chain_exp;
    int           j;
    bit           acc;

    n_vec = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.in_dat    = '0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_dat", 32'(bus.out_dat), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send(8'd80);
    collect({8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80, 8'd80}, 1'b0);
    send(8'd160);
    collect({8'd80, 8'd90, 8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150}, 1'b0);
    send(8'd0);
    collect({8'd160, 8'd140, 8'd120, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20}, 1'b0);
    send(8'd10);
    collect({8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0);
    send(8'd7);
    collect({8'd10, 8'd9, 8'd9, 8'd8, 8'd8, 8'd8, 8'd7, 8'd7}, 1'b0);
    send(8'd0);
    collect({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
    send(8'd255);
    collect({8'd0, 8'd31, 8'd63, 8'd95, 8'd127, 8'd159, 8'd191, 8'd223}, 1'b1);
    send(8'd100);
    collect({8'd255, 8'd235, 8'd216, 8'd196, 8'd177, 8'd158, 8'd138, 8'd119}, 1'b1);

    // Back-to-back: prev = 100, samples 0, 64, 128 offered continuously.
    chain_exp = {8'd100, 8'd87, 8'd75, 8'd62, 8'd50, 8'd37, 8'd25, 8'd12,
                 8'd0, 8'd8, 8'd16, 8'd24, 8'd32, 8'd40, 8'd48, 8'd56,
                 8'd64, 8'd72, 8'd80, 8'd88, 8'd96, 8'd104, 8'd112, 8'd120};
    j = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_dat    = chain_samp(0);
    @(negedge clk);
    j = 1;
    bus.in_dat = chain_samp(1);
    for (int i = 0; i < 24; i++) begin
      chk("chain_valid", 32'(bus.out_valid), 1);
      chk("chain_dat", 32'(bus.out_dat), 32'(chain_exp[191-8*i -: 8]));
      chk("chain_in_ready", 32'(bus.in_ready), (i % 8 == 7) ? 1 : 0);
      acc = bus.in_valid & bus.in_ready;
      @(negedge clk);
      if (acc) begin
        j++;
        if (j < 3) bus.in_dat = chain_samp(j);
        else       bus.in_valid = 1'b0;
      end
    end
    chk("chain_accepts", 32'(j), 3);
    chk("chain_end_valid", 32'(bus.out_valid), 0);

    // Reset in the middle of a segment, at k = 3.
    send(8'd50);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_out_valid", 32'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_last", 32'(bus.out_last), 0);
    chk("mid_rst_dat", 32'(bus.out_dat), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    send(8'd200);
    collect({8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
